// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for rr_mux_reg: N producer channels in,
// one registered consumer slot out.
interface rr_mux_reg_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 32,
    parameter int SEL_BITS = 5
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_BITS-1:0]       sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_BITS-1:0]       out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/rr_mux_reg.sv
// Registered N-channel mux with direct-select and round-robin
// arbitration, one output slot with valid/ready backpressure.
module rr_mux_reg #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 32,
    parameter int SEL_BITS = 5
) (
    input logic         clock,
    input logic         reset,
    rr_mux_reg_if.slave bus
);

    logic [SEL_BITS-1:0] ptr;
    logic [SEL_BITS-1:0] grant;
    logic [SEL_BITS-1:0] hi_idx;
    logic [SEL_BITS-1:0] lo_idx;
    logic [SEL_BITS-1:0] ptr_next;
    logic                hi_ok;
    logic                lo_ok;
    logic                dir_ok;
    logic                grant_ok;
    logic                load_en;
    logic [CHANNELS-1:0] ready;
    logic [WIDTH-1:0]    sel_data;

    logic [WIDTH-1:0]    data_q;
    logic [SEL_BITS-1:0] chan_q;
    logic                valid_q;

    assign load_en = !valid_q || bus.out_ready;

    // Descending scan: the last hit is the lowest index, so hi_idx is
    // the first request at or above ptr and lo_idx the first below it.
    always_comb begin
        hi_ok  = 1'b0;
        lo_ok  = 1'b0;
        dir_ok = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                if (SEL_BITS'(i) >= ptr) begin
                    hi_ok  = 1'b1;
                    hi_idx = SEL_BITS'(i);
                end else begin
                    lo_ok  = 1'b1;
                    lo_idx = SEL_BITS'(i);
                end
                if (bus.sel == SEL_BITS'(i))
                    dir_ok = 1'b1;
            end
        end
        if (bus.mode) begin
            grant_ok = hi_ok || lo_ok;
            grant    = hi_ok ? hi_idx : lo_idx;
        end else begin
            grant_ok = dir_ok;
            grant    = bus.sel;
        end
    end

    always_comb begin
        ready    = '0;
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_BITS'(i)) begin
                sel_data = bus.in_data[i*WIDTH +: WIDTH];
                ready[i] = !reset && load_en && grant_ok;
            end
        end
    end

    assign ptr_next = (grant == SEL_BITS'(CHANNELS - 1))
                    ? '0 : grant + SEL_BITS'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr     <= '0;
        end else if (load_en) begin
            valid_q <= grant_ok;
            if (grant_ok) begin
                data_q <= sel_data;
                chan_q <= grant;
                if (bus.mode)
                    ptr <= ptr_next;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed and random bench for rr_mux_reg against a queue-free
// search model of the grant rules.
module tb_rr_mux_reg;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    rr_mux_reg_if #(.WIDTH(32), .CHANNELS(32), .SEL_BITS(5)) bus ();
    rr_mux_reg_if #(.WIDTH(8), .CHANNELS(5), .SEL_BITS(3)) bus5 ();

    rr_mux_reg #(.WIDTH(32), .CHANNELS(32), .SEL_BITS(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    rr_mux_reg #(.WIDTH(8), .CHANNELS(5), .SEL_BITS(3)) dut5 (
        .clock (clock),
        .reset (reset),
        .bus   (bus5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    bit        m_valid;
    bit [31:0] m_data;
    int        m_chan;
    int        m_ptr;
    int        seq[5];

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        int idx;
        if (!bus.mode) begin
            if (bus.sel < 32 && bus.in_valid[bus.sel])
                return int'(bus.sel);
            return -1;
        end
        for (int k = 0; k < 32; k++) begin
            idx = (m_ptr + k) % 32;
            if (bus.in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_ch(input int c, input logic [31:0] d);
        bus.in_data[c*32 +: 32] = d;
    endtask

    task automatic rand_data();
        for (int c = 0; c < 32; c++) set_ch(c, $urandom);
    endtask

    // Inputs are set before the call, at the falling edge.
    task automatic step();
        int          g;
        bit          load;
        logic [31:0] er;
        g    = model_grant();
        load = !m_valid || bus.out_ready;
        er   = (g >= 0 && load) ? (32'd1 << g) : 32'd0;
        #1;
        chk("in_ready", bus.in_ready, er);
        @(posedge clock);
        if (load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = bus.in_data[g*32 +: 32];
                m_chan  = g;
                if (bus.mode) m_ptr = (g + 1) % 32;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("out_valid", bus.out_valid, m_valid);
        chk("out_data", bus.out_data, m_data);
        chk("out_chan", bus.out_chan, m_chan);
        @(negedge clock);
    endtask

    task automatic step5(input logic [4:0] er, input bit ev,
                         input int ec);
        #1;
        chk("c5_in_ready", bus5.in_ready, er);
        @(posedge clock);
        #1;
        chk("c5_out_valid", bus5.out_valid, ev);
        if (ev) chk("c5_out_chan", bus5.out_chan, ec);
        @(negedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.out_ready = 1'b1;
        bus5.in_data   = '0;
        bus5.in_valid  = '0;
        bus5.mode      = 1'b0;
        bus5.sel       = '0;
        bus5.out_ready = 1'b1;
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_ptr   = 0;

        #3;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_chan", bus.out_chan, 5'd0);
        @(negedge clock);
        reset = 1'b0;

        // load something, then stall it and reset mid-cycle
        bus.sel = 5'd9;
        bus.in_valid = 32'd1 << 9;
        set_ch(9, 32'hA5A5_0009);
        step();
        bus.out_ready = 1'b0;
        bus.mode = 1'b1;
        bus.in_valid = '1;
        step();
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", bus.out_valid, 1'b0);
        chk("async_data", bus.out_data, 32'd0);
        chk("async_ready", bus.in_ready, 32'd0);
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_ptr   = 0;
        @(negedge clock);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        rand_data();
        step();
        chk("rr_first", bus.out_chan, 5'd0);

        // direct select
        bus.mode = 1'b0;
        bus.sel = 5'd17;
        bus.in_valid = 32'd1 << 17;
        set_ch(17, 32'hDEAD_BEEF);
        step();
        chk("dir17_data", bus.out_data, 32'hDEAD_BEEF);
        chk("dir17_chan", bus.out_chan, 5'd17);
        bus.sel = 5'd31;
        step();
        chk("dir31_none", bus.out_valid, 1'b0);

        // round-robin fairness and wrap
        bus.mode = 1'b1;
        bus.in_valid = (32'd1 << 3) | (32'd1 << 10) | (32'd1 << 31);
        seq = '{3, 10, 31, 3, 10};
        for (int k = 0; k < 5; k++) begin
            rand_data();
            step();
            chk("rr_seq", bus.out_chan, seq[k]);
        end

        // direct traffic must not disturb the round-robin pointer
        bus.mode = 1'b0;
        bus.sel = 5'd2;
        bus.in_valid = 32'd1 << 2;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            step();
        end
        bus.mode = 1'b1;
        bus.in_valid = (32'd1 << 2) | (32'd1 << 12);
        step();
        chk("rr_resume", bus.out_chan, 5'd12);

        // backpressure
        bus.mode = 1'b0;
        bus.sel = 5'd5;
        bus.in_valid = 32'd1 << 5;
        set_ch(5, 32'h1234_5678);
        step();
        bus.sel = 5'd6;
        bus.in_valid = 32'd1 << 6;
        set_ch(6, 32'hCAFE_F00D);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_hold", bus.out_data, 32'h1234_5678);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_release", bus.out_data, 32'hCAFE_F00D);
        bus.in_valid = '0;
        step();

        // five-channel instance
        bus5.in_data = 40'h44_33_22_11_00;
        bus5.in_valid = 5'b11111;
        bus5.sel = 3'd6;
        step5(5'b00000, 1'b0, 0);
        bus5.sel = 3'd4;
        step5(5'b10000, 1'b1, 4);
        bus5.mode = 1'b1;
        bus5.in_valid = 5'b10010;
        step5(5'b00010, 1'b1, 1);
        step5(5'b10000, 1'b1, 4);
        step5(5'b00010, 1'b1, 1);
        bus5.in_valid = '0;
        step5(5'b00000, 1'b0, 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rand_data();
            bus.mode = 1'($urandom);
            bus.sel = 5'($urandom);
            bus.in_valid = $urandom & $urandom & $urandom;
            bus.out_ready = ($urandom % 4) != 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised successor to the fixed 32-way, 32-bit select multiplexer.
- Registered N-channel multiplexer with valid/ready handshakes on every input and on the output.
- Two modes: direct select (index-driven, as in the register-file and writeback paths) and round-robin arbitration (shared sprite/controller/memory request paths).
- Sits between multiple producers and one consumer; provides one registered output slot with backpressure.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 32, number of input channels, 2..32.
- SEL_BITS, 5, width of sel and out_chan; must satisfy 2^SEL_BITS >= CHANNELS.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel request.
- in_ready  output  CHANNELS  per-channel accept, one-hot or zero.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SEL_BITS  channel index, used in direct mode only.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_BITS  index of the channel that produced out_data.
- out_valid  output  1  output slot holds data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (async, takes effect immediately): out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0. in_ready is all zero while reset is high.
- load_en = !out_valid || out_ready. Consumption and refill in the same cycle are allowed, giving full throughput of 1 transfer per cycle.
- Grant in direct mode:
  - grant = sel when sel < CHANNELS and in_valid[sel]=1.
  - Otherwise no grant; sel >= CHANNELS never grants.
- Grant in round-robin mode:
  - grant = first i with in_valid[i]=1, searching ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1 (wraps modulo CHANNELS).
  - No grant if all in_valid are 0.
- in_ready[grant] = load_en, driven combinationally in the same cycle. All other in_ready bits are 0. No combinational path from out_ready to in_ready other than through load_en.
- On a rising edge with load_en and a grant (the handshake):
  - out_data <= selected channel data; out_chan <= grant; out_valid <= 1.
  - In round-robin mode only: ptr <= (grant+1) mod CHANNELS, so wrap goes CHANNELS-1 -> 0.
- On a rising edge with load_en and no grant: out_valid <= 0; out_data and out_chan hold their last values.
- When out_valid=1 and out_ready=0:
  - out_data, out_chan and out_valid hold.
  - in_ready stays all zero.
  - ptr holds.
- Latency: data presented on an accepted cycle appears on out_data one clock later.
- Mode and sel changes are sampled only at grant time. They never alter a held output.
- ptr is not updated in direct mode. Round-robin resumes from the last round-robin ptr.
- Producers must hold in_data and in_valid until accepted. The block does not store unaccepted data.
- Reset asserted mid-transfer drops any held output. No partial state survives.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_data=0 and in_ready=0 immediately; after release, ptr=0, so with in_valid=all ones in round-robin mode the first grant is channel 0.
- Direct select: mode=0, sel=17, channel 17 data 0xDEADBEEF, in_valid[17]=1, out_ready=1 -> in_ready=1<<17 that cycle; next cycle out_data=0xDEADBEEF, out_chan=17, out_valid=1. Then sel=31 with in_valid[31]=0 -> out_valid=0 next cycle.
- Round-robin fairness and wrap: mode=1, in_valid bits 3, 10 and 31 held high, out_ready=1 -> out_chan sequence 3, 10, 31, 3, 10, one per cycle. ptr wraps 0 after the grant to 31.
- Backpressure: output holds channel 5 data 0x12345678, out_ready=0 for 4 cycles while channel 6 is valid -> out_data stable, in_ready=0 throughout. Raise out_ready -> channel 6 is loaded on that same edge with no bubble.
- Mode switch: in round-robin mode with ptr=11 after a grant to 10, switch to mode=0 with sel=2 for 3 transfers, then back to mode=1 with in_valid bits 2 and 12 high -> next grant is 12, not 2.
- Non-power-of-two parameters: CHANNELS=5, SEL_BITS=3, mode=0, sel=6, in_valid=all ones -> no grant, in_ready=0, out_valid=0.
